// File: rtl/prop_window_monitor.sv
// -----------------------------------------------------------------------------
// prop_window_monitor
//
// Synthesizable stand-in for a clocked, named property with a "disable iff"
// guard. While a run is active, every rising clock edge samples the property
// expression and classifies the sample:
//   - disabled: disable_i high
//   - pass:     disable_i low and sig_i high
//   - fail:     disable_i low and sig_i low
// Results accumulate in saturating counters. After MAX_CYC+1 evaluations the
// block parks in DONE and holds its results until cleared.
//
// Ports
//   clk            in   single clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   begins a run when sampled high in IDLE
//   clr            in   synchronous clear back to IDLE (highest priority)
//   disable_i      in   disable-iff condition, sampled on the clock edge
//   sig_i          in   property expression
//   cyc_o          out  samples evaluated in the current run
//   pass_cnt       out  saturating count of passing samples
//   fail_cnt       out  saturating count of failing samples
//   dis_cnt        out  saturating count of disabled samples
//   fail_o         out  one-cycle pulse per failing sample
//   fail_seen      out  sticky: at least one failure in this run
//   first_fail_cyc out  cyc_o value of the first failing sample
//   busy           out  high in RUN
//   done_o         out  high in DONE
// -----------------------------------------------------------------------------
module prop_window_monitor #(
    parameter int CYC_W   = 32,
    parameter int CNT_W   = 16,
    parameter int MAX_CYC = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic             disable_i,
    input  logic             sig_i,
    output logic [CYC_W-1:0] cyc_o,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] dis_cnt,
    output logic             fail_o,
    output logic             fail_seen,
    output logic [CYC_W-1:0] first_fail_cyc,
    output logic             busy,
    output logic             done_o
);

    localparam logic [CYC_W-1:0] LAST_CYC_C = CYC_W'(MAX_CYC);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_next_s;

    logic [CYC_W-1:0] cyc_r;
    logic [CNT_W-1:0] pass_r;
    logic [CNT_W-1:0] fail_r;
    logic [CNT_W-1:0] dis_r;
    logic             fail_pulse_r;
    logic             fail_seen_r;
    logic [CYC_W-1:0] first_fail_r;
    logic             busy_r;
    logic             done_r;

    logic [CYC_W-1:0] cyc_next_s;
    logic [CNT_W-1:0] pass_next_s;
    logic [CNT_W-1:0] fail_next_s;
    logic [CNT_W-1:0] dis_next_s;
    logic             fail_pulse_next_s;
    logic             fail_seen_next_s;
    logic [CYC_W-1:0] first_fail_next_s;
    logic             busy_next_s;
    logic             done_next_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; clr overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        if (clr) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The sample taken at cyc == MAX_CYC is the last of the run.
                    if (cyc_r == LAST_CYC_C) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags follow the state being entered so they are registered
    // alongside it rather than decoded from it.
    always_comb begin
        busy_next_s = 1'b0;
        done_next_s = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
            ST_RUN: begin
                busy_next_s = 1'b1;
                done_next_s = 1'b0;
            end
            ST_DONE: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
                done_next_s = 1'b0;
            end
        endcase
    end

    // Sample classification and result accumulation.
    always_comb begin
        cyc_next_s        = cyc_r;
        pass_next_s       = pass_r;
        fail_next_s       = fail_r;
        dis_next_s        = dis_r;
        fail_pulse_next_s = 1'b0;
        fail_seen_next_s  = fail_seen_r;
        first_fail_next_s = first_fail_r;
        if (clr) begin
            cyc_next_s        = '0;
            pass_next_s       = '0;
            fail_next_s       = '0;
            dis_next_s        = '0;
            fail_seen_next_s  = 1'b0;
            first_fail_next_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Entry edge into RUN clears results; no sample is taken.
                    if (start) begin
                        cyc_next_s        = '0;
                        pass_next_s       = '0;
                        fail_next_s       = '0;
                        dis_next_s        = '0;
                        fail_seen_next_s  = 1'b0;
                        first_fail_next_s = '0;
                    end else begin
                        cyc_next_s = cyc_r;
                    end
                end
                ST_RUN: begin
                    if (disable_i) begin
                        dis_next_s = sat_inc(dis_r);
                    end else if (sig_i) begin
                        pass_next_s = sat_inc(pass_r);
                    end else begin
                        // The pulse is independent of counter saturation.
                        fail_next_s       = sat_inc(fail_r);
                        fail_pulse_next_s = 1'b1;
                        if (!fail_seen_r) begin
                            fail_seen_next_s  = 1'b1;
                            first_fail_next_s = cyc_r;
                        end else begin
                            fail_seen_next_s  = fail_seen_r;
                        end
                    end
                    cyc_next_s = cyc_r + CYC_W'(1);
                end
                ST_DONE: begin
                    cyc_next_s = cyc_r;
                end
                default: begin
                    cyc_next_s = cyc_r;
                end
            endcase
        end
    end

    // Result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r        <= '0;
            pass_r       <= '0;
            fail_r       <= '0;
            dis_r        <= '0;
            fail_pulse_r <= 1'b0;
            fail_seen_r  <= 1'b0;
            first_fail_r <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            cyc_r        <= cyc_next_s;
            pass_r       <= pass_next_s;
            fail_r       <= fail_next_s;
            dis_r        <= dis_next_s;
            fail_pulse_r <= fail_pulse_next_s;
            fail_seen_r  <= fail_seen_next_s;
            first_fail_r <= first_fail_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
        end
    end

    assign cyc_o          = cyc_r;
    assign pass_cnt       = pass_r;
    assign fail_cnt       = fail_r;
    assign dis_cnt        = dis_r;
    assign fail_o         = fail_pulse_r;
    assign fail_seen      = fail_seen_r;
    assign first_fail_cyc = first_fail_r;
    assign busy           = busy_r;
    assign done_o         = done_r;

endmodule

// File: tb/tb_prop_window_monitor.sv
module tb_prop_window_monitor;

    localparam int CYC_W   = 32;
    localparam int CNT_W   = 16;
    localparam int CNT_W2  = 3;
    localparam int MAX_CYC = 11;
    localparam int RUN_LEN = MAX_CYC + 1;
    localparam int SAT2    = (1 << CNT_W2) - 1;
    localparam int VW      = 4 + 2 * CYC_W + 3 * CNT_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clr = 1'b0;
    logic disable_i = 1'b0;
    logic sig_i = 1'b0;

    logic [CYC_W-1:0] cyc_o, first_fail_cyc;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, dis_cnt;
    logic             fail_o, fail_seen, busy, done_o;

    logic [CYC_W-1:0]  cyc_o2, first_fail_cyc2;
    logic [CNT_W2-1:0] pass_cnt2, fail_cnt2, dis_cnt2;
    logic              fail_o2, fail_seen2, busy2, done_o2;

    prop_window_monitor #(.CYC_W(CYC_W), .CNT_W(CNT_W), .MAX_CYC(MAX_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .disable_i(disable_i), .sig_i(sig_i),
        .cyc_o(cyc_o), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .dis_cnt(dis_cnt),
        .fail_o(fail_o), .fail_seen(fail_seen), .first_fail_cyc(first_fail_cyc),
        .busy(busy), .done_o(done_o)
    );

    // Narrow-counter instance on the same stimulus, for saturation.
    prop_window_monitor #(.CYC_W(CYC_W), .CNT_W(CNT_W2), .MAX_CYC(MAX_CYC)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr),
        .disable_i(disable_i), .sig_i(sig_i),
        .cyc_o(cyc_o2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2), .dis_cnt(dis_cnt2),
        .fail_o(fail_o2), .fail_seen(fail_seen2), .first_fail_cyc(first_fail_cyc2),
        .busy(busy2), .done_o(done_o2)
    );

    always #5 clk = ~clk;

    wire all_zero = ~|{cyc_o, first_fail_cyc, pass_cnt, fail_cnt, dis_cnt,
                       fail_o, fail_seen, busy, done_o,
                       cyc_o2, first_fail_cyc2, pass_cnt2, fail_cnt2, dis_cnt2,
                       fail_o2, fail_seen2, busy2, done_o2};

    wire [VW-1:0] got_v = {fail_o, cyc_o, pass_cnt, fail_cnt, dis_cnt,
                           fail_seen, first_fail_cyc, busy, done_o};

    int tests_run = 0;
    int failures  = 0;
    int exp_q[$];

    int   m_cyc, m_pass, m_fail, m_dis, m_fail2, m_ffc;
    logic m_fseen;
    int   pulses, pulses2;

    function automatic logic [VW-1:0] model_vec(input logic f, input logic b, input logic d);
        return {f, CYC_W'(m_cyc), CNT_W'(m_pass), CNT_W'(m_fail), CNT_W'(m_dis),
                m_fseen, CYC_W'(m_ffc), b, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_cyc = 0; m_pass = 0; m_fail = 0; m_dis = 0; m_fail2 = 0; m_ffc = 0;
        m_fseen = 1'b0; pulses = 0; pulses2 = 0;
    endtask

    task automatic start_run(input string name);
        logic [VW-1:0] exp_v;
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
        exp_v = model_vec(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s_start: got %h expected %h", name, got_v, exp_v);
        end
    endtask

    task automatic do_clear(input string name);
        clr = 1'b1;
        step();
        clr = 1'b0;
        model_clear();
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL %s_clear: outputs not all zero (busy=%b done=%b cyc=%0d)", name, busy, done_o, cyc_o);
        end
    endtask

    // Drive one sample, queue its expected class, and check once the DUT shows it.
    task automatic sample(input string name, input logic d, input logic s);
        int cls;
        logic last;
        logic [VW-1:0] exp_v;
        disable_i = d;
        sig_i = s;
        exp_q.push_back(d ? 0 : (s ? 1 : 2));
        step();
        cls = exp_q.pop_front();
        if (cls == 0) m_dis++;
        else if (cls == 1) m_pass++;
        else begin
            m_fail++;
            if (m_fail2 < SAT2) m_fail2++;
            if (!m_fseen) begin
                m_fseen = 1'b1;
                m_ffc = m_cyc;
            end
        end
        m_cyc++;
        last = (m_cyc == RUN_LEN);
        if (fail_o === 1'b1) pulses++;
        if (fail_o2 === 1'b1) pulses2++;
        exp_v = model_vec(cls == 2, !last, last);
        tests_run++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL %s_s%0d: got %h expected %h", name, m_cyc - 1, got_v, exp_v);
        end
        tests_run++;
        if ({fail_o2, cyc_o2, fail_cnt2, done_o2} !== {cls == 2, CYC_W'(m_cyc), CNT_W2'(m_fail2), last}) begin
            failures++;
            $display("FAIL %s_sat_s%0d: got fail_o=%b cyc=%0d fail_cnt=%0d done=%b expected fail_o=%b cyc=%0d fail_cnt=%0d done=%b",
                     name, m_cyc - 1, fail_o2, cyc_o2, fail_cnt2, done_o2, cls == 2, m_cyc, m_fail2, last);
        end
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: outputs not all zero (busy=%b done=%b cyc=%0d)", busy, done_o, cyc_o);
        end
        #10 rst_n = 1'b1;
        step();
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle: outputs not all zero after release (busy=%b)", busy);
        end
    endtask

    task automatic test_disabled();
        start_run("dis");
        for (int i = 0; i < RUN_LEN; i++) sample("dis", m_cyc <= 10, 1'b1);
        tests_run++;
        if ({dis_cnt, pass_cnt, fail_cnt, fail_seen, cyc_o, done_o} !== {CNT_W'(11), CNT_W'(1), CNT_W'(0), 1'b0, CYC_W'(12), 1'b1}) begin
            failures++;
            $display("FAIL dis_result: got dis=%0d pass=%0d fail=%0d seen=%b cyc=%0d done=%b expected 11 1 0 0 12 1",
                     dis_cnt, pass_cnt, fail_cnt, fail_seen, cyc_o, done_o);
        end
        do_clear("dis");
    endtask

    task automatic test_const_fail();
        start_run("fail");
        for (int i = 0; i < RUN_LEN; i++) sample("fail", 1'b0, 1'b0);
        tests_run++;
        if ({fail_cnt, fail_seen, first_fail_cyc, pulses} !== {CNT_W'(12), 1'b1, CYC_W'(0), 32'd12}) begin
            failures++;
            $display("FAIL fail_result: got fail=%0d seen=%b first=%0d pulses=%0d expected 12 1 0 12",
                     fail_cnt, fail_seen, first_fail_cyc, pulses);
        end
        tests_run++;
        if ({fail_cnt2, pulses2, cyc_o2, done_o2} !== {CNT_W2'(7), 32'd12, CYC_W'(12), 1'b1}) begin
            failures++;
            $display("FAIL sat_result: got fail=%0d pulses=%0d cyc=%0d done=%b expected 7 12 12 1",
                     fail_cnt2, pulses2, cyc_o2, done_o2);
        end
        do_clear("fail");
    endtask

    task automatic test_toggle();
        start_run("tog");
        for (int i = 0; i < RUN_LEN; i++) sample("tog", 1'b0, (i % 2) == 0);
        tests_run++;
        if ({pass_cnt, fail_cnt, first_fail_cyc} !== {CNT_W'(6), CNT_W'(6), CYC_W'(1)}) begin
            failures++;
            $display("FAIL tog_result: got pass=%0d fail=%0d first=%0d expected 6 6 1",
                     pass_cnt, fail_cnt, first_fail_cyc);
        end
        do_clear("tog");
    endtask

    task automatic test_clear_mid_run();
        start_run("clr");
        for (int i = 0; i < 5; i++) sample("clr", 1'b0, 1'b0);
        disable_i = 1'b0;
        sig_i = 1'b0;
        do_clear("clr_mid");
        step();
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL clr_stay_idle: outputs not zero (busy=%b cyc=%0d)", busy, cyc_o);
        end
        start_run("clr_fresh");
        for (int i = 0; i < RUN_LEN; i++) sample("clr_fresh", 1'b0, 1'b1);
        tests_run++;
        if ({pass_cnt, fail_cnt, dis_cnt, done_o} !== {CNT_W'(12), CNT_W'(0), CNT_W'(0), 1'b1}) begin
            failures++;
            $display("FAIL clr_fresh_result: got pass=%0d fail=%0d dis=%0d done=%b expected 12 0 0 1",
                     pass_cnt, fail_cnt, dis_cnt, done_o);
        end
        do_clear("clr_fresh");
    endtask

    task automatic test_reset_mid_run();
        start_run("rst");
        for (int i = 0; i < 7; i++) sample("rst", 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL rst_async: outputs not zero before edge (busy=%b cyc=%0d fail=%0d)", busy, cyc_o, fail_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        model_clear();
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL rst_idle: outputs not zero after release (busy=%b cyc=%0d)", busy, cyc_o);
        end
    endtask

    task automatic test_start_clr();
        start = 1'b1;
        clr = 1'b1;
        step();
        start = 1'b0;
        clr = 1'b0;
        step();
        tests_run++;
        if (all_zero !== 1'b1) begin
            failures++;
            $display("FAIL start_clr: left IDLE (busy=%b done=%b cyc=%0d)", busy, done_o, cyc_o);
        end
    endtask

    task automatic test_start_in_done();
        logic [VW-1:0] exp_v;
        start_run("done");
        for (int i = 0; i < RUN_LEN; i++) sample("done", (i % 3) == 0, (i % 2) == 1);
        tests_run++;
        if (int'(pass_cnt) + int'(fail_cnt) + int'(dis_cnt) != RUN_LEN) begin
            failures++;
            $display("FAIL done_sum: got %0d expected %0d", int'(pass_cnt) + int'(fail_cnt) + int'(dis_cnt), RUN_LEN);
        end
        start = 1'b1;
        disable_i = 1'b0;
        sig_i = 1'b0;
        step();
        step();
        start = 1'b0;
        exp_v = model_vec(1'b0, 1'b0, 1'b1);
        tests_run++;
        if (got_v !== exp_v) begin
            failures++;
            $display("FAIL done_hold: got %h expected %h", got_v, exp_v);
        end
        do_clear("done");
    endtask

    initial begin
        model_clear();
        test_reset();
        test_disabled();
        test_const_fail();
        test_toggle();
        test_clear_mid_run();
        test_reset_mid_run();
        test_start_clr();
        test_start_in_done();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
